// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, FSM encoding, latched request layout and address checks.
// Pure declarations; no timing or flow control lives here.
package apb_pkg;

  localparam int APB_AW     = 12;
  localparam int APB_DW     = 32;
  localparam int BYTE_OFS_W = 2;
  localparam int WORD_AW    = APB_AW - BYTE_OFS_W;
  localparam int WAIT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [WORD_AW-1:0] word;
    logic               write;
    logic [APB_DW-1:0]  wdata;
    logic               err;
  } apb_req_t;

  // Misaligned byte address, or word index beyond the populated SRAM.
  function automatic logic addr_err(input logic [APB_AW-1:0] addr, input int unsigned depth);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[BYTE_OFS_W-1:0] != '0);
    out_of_range = (32'(addr[APB_AW-1:BYTE_OFS_W]) >= depth);
    return misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/apb_ws_sram_slave_if.sv
// APB3 bus bundle between a master and the wait-state SRAM responder.
// Master drives request fields; slave returns pready/prdata/pslverr.
interface apb_ws_sram_slave_if;

  logic                      psel;
  logic                      penable;
  logic [apb_pkg::APB_AW-1:0] paddr;
  logic                      pwrite;
  logic [apb_pkg::APB_DW-1:0] pwdata;
  logic                      pready;
  logic [apb_pkg::APB_DW-1:0] prdata;
  logic                      pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/sp_sram.sv
// Single-port synchronous SRAM: one access per cycle, read data registered (1-cycle latency).
// No flow control; read data holds until the next read.
module sp_sram #(
  parameter int MEM_DEPTH = 1024,
  parameter int MEM_ABIT  = 10,
  parameter int MEM_DW    = 32
) (
  input  logic                clk,
  input  logic                cs,
  input  logic                we,
  input  logic [MEM_ABIT-1:0] addr,
  input  logic [MEM_DW-1:0]   wdata,
  output logic [MEM_DW-1:0]   rdata
);

  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [MEM_DW-1:0] mem [MEM_DEPTH];
  logic [MEM_DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (cs && we) begin
      mem[addr[IW-1:0]] <= wdata;
    end
    if (cs && !we) begin
      rdata_q <= mem[addr[IW-1:0]];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/apb_ws_sram_slave.sv
// APB3 SRAM responder: WAIT_CYC wait states before pready, pslverr on misaligned/out-of-range.
// Transfer = 3 + WAIT_CYC cycles; master stalls by holding penable, drops psel to abort.
module apb_ws_sram_slave #(
  parameter int MEM_DEPTH = 1024,
  parameter int MEM_ABIT  = 10,
  parameter int MEM_DW    = 32,
  parameter int WAIT_CYC  = 2
) (
  input logic                clk,
  input logic                rst,
  apb_ws_sram_slave_if.slave bus
);

  import apb_pkg::*;

  apb_state_e          state_q, state_d;
  apb_state_e          phase;
  apb_req_t            req_q, req_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                pready_int;
  logic                setup_err;
  logic                mem_cs;
  logic                mem_we;
  logic [MEM_ABIT-1:0] mem_addr;
  logic [MEM_DW-1:0]   mem_rdata;

  // pready decodes registered state only, so it never loops back through the master.
  assign pready_int = (state_q == ST_ACCESS) && (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = bus.paddr[MEM_ABIT+BYTE_OFS_W-1:BYTE_OFS_W];
    setup_err = addr_err(bus.paddr, MEM_DEPTH);

    // SETUP is the live setup cycle seen from IDLE; only IDLE/ACCESS are ever registered.
    phase = state_q;
    if ((state_q == ST_IDLE) && bus.psel && !bus.penable) begin
      phase = ST_SETUP;
    end

    case (phase)
      ST_SETUP: begin
        state_d    = ST_ACCESS;
        req_d.word  = bus.paddr[APB_AW-1:BYTE_OFS_W];
        req_d.write = bus.pwrite;
        req_d.wdata = bus.pwdata;
        req_d.err   = setup_err;
        cnt_d      = WAIT_W'(WAIT_CYC);
        mem_cs     = !bus.pwrite && !setup_err;
      end
      ST_ACCESS: begin
        if (!bus.psel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (bus.penable && pready_int) begin
          state_d  = ST_IDLE;
          mem_cs   = req_q.write && !req_q.err;
          mem_we   = req_q.write && !req_q.err;
          mem_addr = req_q.word[MEM_ABIT-1:0];
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end

  sp_sram #(
    .MEM_DEPTH (MEM_DEPTH),
    .MEM_ABIT  (MEM_ABIT),
    .MEM_DW    (MEM_DW)
  ) u_mem (
    .clk   (clk),
    .cs    (mem_cs),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (req_q.wdata),
    .rdata (mem_rdata)
  );

  assign bus.pready  = pready_int;
  assign bus.pslverr = pready_int && req_q.err;
  assign bus.prdata  = (pready_int && !req_q.write && !req_q.err) ? mem_rdata : '0;

endmodule

// File: tb/tb_apb_ws_sram_slave.sv
// Bench for apb_ws_sram_slave: three instances (0/3/5 wait states, 1024/512/1024 words) on a muxed bus.
// Stimulus queues expected responses; a negedge monitor pops and compares on each completed transfer.
module tb_apb_ws_sram_slave;

  import apb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        pready, pslverr;
  logic [31:0] prdata;
  int          sel;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] rd;
    logic        err;
    int          waits;
  } exp_t;

  exp_t sb_q[$];

  apb_ws_sram_slave_if if0 ();
  apb_ws_sram_slave_if if1 ();
  apb_ws_sram_slave_if if2 ();

  assign if0.psel = psel && (sel == 0);
  assign if1.psel = psel && (sel == 1);
  assign if2.psel = psel && (sel == 2);
  assign if0.penable = penable;
  assign if1.penable = penable;
  assign if2.penable = penable;
  assign if0.paddr = paddr;
  assign if1.paddr = paddr;
  assign if2.paddr = paddr;
  assign if0.pwrite = pwrite;
  assign if1.pwrite = pwrite;
  assign if2.pwrite = pwrite;
  assign if0.pwdata = pwdata;
  assign if1.pwdata = pwdata;
  assign if2.pwdata = pwdata;

  always_comb begin
    pready  = if0.pready;
    pslverr = if0.pslverr;
    prdata  = if0.prdata;
    if (sel == 1) begin
      pready  = if1.pready;
      pslverr = if1.pslverr;
      prdata  = if1.prdata;
    end else if (sel == 2) begin
      pready  = if2.pready;
      pslverr = if2.pslverr;
      prdata  = if2.prdata;
    end
  end

  apb_ws_sram_slave #(.MEM_DEPTH(1024), .MEM_ABIT(10), .MEM_DW(32), .WAIT_CYC(0))
    u_d0 (.clk(clk), .rst(rst), .bus(if0));
  apb_ws_sram_slave #(.MEM_DEPTH(512), .MEM_ABIT(10), .MEM_DW(32), .WAIT_CYC(3))
    u_d1 (.clk(clk), .rst(rst), .bus(if1));
  apb_ws_sram_slave #(.MEM_DEPTH(1024), .MEM_ABIT(10), .MEM_DW(32), .WAIT_CYC(5))
    u_d2 (.clk(clk), .rst(rst), .bus(if2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] peek(input int s, input int w);
    case (s)
      0:       return u_d0.u_mem.mem[w];
      1:       return u_d1.u_mem.mem[w];
      default: return u_d2.u_mem.mem[w];
    endcase
  endfunction

  // Called just after a posedge; leaves the bus just after a posedge.
  task automatic xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_waits,
                      input bit b2b);
    exp_t e;
    exp_t dropped;
    logic got;
    e.addr  = a;
    e.rd    = exp_rd;
    e.err   = exp_err;
    e.waits = exp_waits;
    sb_q.push_back(e);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = pready;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout addr=0x%03h: pready not seen within 40 cycles", a);
      dropped = sb_q.pop_back();
    end
    @(posedge clk); #1;
    if (!b2b) begin
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rdat(input int s, input int i);
    return 32'h5A00_0000 ^ (32'(s) << 20) ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Monitor: counts wait cycles and scores every completed transfer.
  initial begin
    int   waits;
    exp_t e;
    waits = 0;
    forever begin
      @(negedge clk);
      if (rst || !psel) begin
        waits = 0;
      end else if (penable) begin
        if (!pready) begin
          waits++;
        end else begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_pop: pready with no pending transfer at addr 0x%03h", paddr);
          end else begin
            e = sb_q.pop_front();
            chk($sformatf("pslverr@%03h", e.addr), 32'(pslverr), 32'(e.err));
            chk($sformatf("prdata@%03h", e.addr), prdata, e.rd);
            chk($sformatf("waits@%03h", e.addr), 32'(waits), 32'(e.waits));
          end
          waits = 0;
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within 20000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; sel = 0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk($sformatf("rst_pready_%0d", s), 32'(pready), 32'h0);
      chk($sformatf("rst_pslverr_%0d", s), 32'(pslverr), 32'h0);
      chk($sformatf("rst_prdata_%0d", s), prdata, 32'h0);
    end
    sel = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_pready", 32'(pready), 32'h0);
    end
    @(posedge clk); #1;

    // Zero wait states: write/read, misalignment, word 512 and last word of a 1024-deep array.
    sel = 0;
    u_d0.u_mem.mem[0]    = 32'h0102_0304;
    u_d0.u_mem.mem[512]  = 32'h55AA_55AA;
    u_d0.u_mem.mem[1023] = 32'h0F0E_0D0C;
    xfer(1'b1, 12'h3FC, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 1'b0);
    chk("d0_mem255", peek(0, 255), 32'hDEAD_BEEF);
    xfer(1'b0, 12'h3FC, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    xfer(1'b1, 12'h002, 32'hA5A5_A5A5, 32'h0, 1'b1, 0, 1'b0);
    chk("d0_mem0_kept", peek(0, 0), 32'h0102_0304);
    xfer(1'b0, 12'h800, 32'h0, 32'h55AA_55AA, 1'b0, 0, 1'b0);
    xfer(1'b0, 12'hFFC, 32'h0, 32'h0F0E_0D0C, 1'b0, 0, 1'b0);
    xfer(1'b0, 12'hFFE, 32'h0, 32'h0, 1'b1, 0, 1'b0);

    // Three wait states, 512-word array: range edge and back-to-back write then read.
    sel = 1;
    u_d1.u_mem.mem[0] = 32'h1234_5678;
    u_d1.u_mem.mem[4] = 32'h0BAD_F00D;
    xfer(1'b0, 12'h000, 32'h0, 32'h1234_5678, 1'b0, 3, 1'b0);
    xfer(1'b0, 12'h800, 32'h0, 32'h0, 1'b1, 3, 1'b0);
    xfer(1'b1, 12'h7FC, 32'hCAFE_F00D, 32'h0, 1'b0, 3, 1'b1);
    xfer(1'b0, 12'h7FC, 32'h0, 32'hCAFE_F00D, 1'b0, 3, 1'b0);
    chk("d1_mem511", peek(1, 511), 32'hCAFE_F00D);

    // Abort a write during wait states.
    psel = 1'b1; penable = 1'b0; paddr = 12'h010; pwrite = 1'b1; pwdata = 32'h1111_2222;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("abort_pready", 32'(pready), 32'h0);
    @(posedge clk); #1;
    chk("abort_state", 32'(u_d1.state_q), 32'(ST_IDLE));
    chk("abort_mem4", peek(1, 4), 32'h0BAD_F00D);
    xfer(1'b0, 12'h010, 32'h0, 32'h0BAD_F00D, 1'b0, 3, 1'b0);

    // Reset while a write shows pready: outputs clear asynchronously, no commit.
    psel = 1'b1; penable = 1'b0; paddr = 12'h010; pwrite = 1'b1; pwdata = 32'h3333_4444;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_pready", 32'(pready), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_pready", 32'(pready), 32'h0);
    chk("async_rst_pslverr", 32'(pslverr), 32'h0);
    chk("async_rst_prdata", prdata, 32'h0);
    chk("async_rst_state", 32'(u_d1.state_q), 32'(ST_IDLE));
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; rst = 1'b0;
    chk("rst_mem4", peek(1, 4), 32'h0BAD_F00D);
    @(negedge clk);
    chk("post_rst_pready", 32'(pready), 32'h0);
    @(posedge clk); #1;
    xfer(1'b0, 12'h010, 32'h0, 32'h0BAD_F00D, 1'b0, 3, 1'b0);

    // Write/read sweep on every instance; reads run back-to-back.
    for (int s = 0; s < 3; s++) begin
      int wt;
      wt = (s == 0) ? 0 : ((s == 1) ? 3 : 5);
      sel = s;
      for (int i = 0; i < 16; i++) begin
        xfer(1'b1, 12'((300 + i * 13) * 4), rdat(s, i), 32'h0, 1'b0, wt, 1'b0);
      end
      for (int i = 0; i < 16; i++) begin
        xfer(1'b0, 12'((300 + i * 13) * 4), 32'h0, rdat(s, i), 1'b0, wt, (i != 15));
      end
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("mem_d%0d_w%0d", s, 300 + i * 13), peek(s, 300 + i * 13), rdat(s, i));
      end
    end

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_ws_sram_slave.md
# apb_ws_sram_slave

APB3 responder that fronts the single-port SRAM with a programmable number of wait states and an error response. It is the slave-side counterpart to the APB master bench model; the same `apb_write`/`apb_read` tasks must run unmodified against it. Unlike the zero-wait SRAM slave, it exercises the master's `pready` polling loop and adds `pslverr` for misaligned and out-of-range accesses.

## Interface

- `MEM_DEPTH`, 1024: SRAM words.
- `MEM_ABIT`, 10: word-address width; `MEM_DEPTH <= 2**MEM_ABIT`.
- `MEM_DW`, 32: data width.
- `WAIT_CYC`, 2: wait states inserted before `pready`; legal range 0..15.
- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: reset, asynchronous and active-high.
- `psel` input 1: APB select.
- `penable` input 1: APB enable (access phase).
- `paddr` input 12: byte address; bits [1:0] must be 0.
- `pwrite` input 1: 1 = write, 0 = read.
- `pwdata` input 32: write data.
- `pready` output 1: transfer completes this cycle.
- `prdata` output 32: read data; valid only while `pready & ~pwrite & ~pslverr`.
- `pslverr` output 1: error response; valid only while `pready`.

## Operation

- The FSM has three states: IDLE, SETUP, ACCESS.
- **IDLE:**
  - `psel & ~penable` is a setup cycle; at the next edge go to SETUP.
  - `penable` without a prior setup is ignored.
- **SETUP edge** (posedge that ends the setup cycle):
  - Latch `paddr`, `pwrite`, `pwdata`.
  - Load the wait counter with `WAIT_CYC`.
  - Compute `err = (paddr[1:0] != 0) | (paddr[11:2] >= MEM_DEPTH)`.
  - For a non-error read, issue the SRAM read during the setup cycle. Chip select comes combinationally from `psel & ~penable & ~pwrite`. SRAM output is registered at this edge.
  - Go to ACCESS.
- **ACCESS:**
  - `pready = (cnt == 0)`. It decodes from registered state only and has no combinational path from inputs.
  - While `cnt != 0`, decrement each cycle.
  - At the edge where `psel & penable & pready`, the transfer completes and the FSM returns to IDLE.
  - A new setup is accepted from IDLE on the following cycle.
- **Write:** the SRAM write is committed at the completion edge, only if `~err`. An error write leaves memory unchanged.
- **Read:** `prdata` = SRAM dout while `pready & ~pwrite & ~err`, otherwise 0. SRAM dout is held stable throughout ACCESS (no further chip select).
- **pslverr:** equals `err & pready`; otherwise 0.
- **Abort:** `psel` deasserted while in ACCESS before `pready` means return to IDLE with no write. `pready`, `pslverr`, `prdata` go to 0 the next cycle.
- **Reset:** `rst` forces IDLE with `pready`, `pslverr`, `prdata`, counter and latched registers all 0. Reset asserted mid-write commits no write. SRAM contents are not cleared.

## Timing

- Transfer length is `3 + WAIT_CYC` cycles, counting the setup cycle and the first idle cycle after `pready`.
- The access phase is `WAIT_CYC + 1` cycles, with `pready` high in the last one.
- With `WAIT_CYC = 0`, `pready` rises in the first access cycle (T2), giving standard APB zero-wait behaviour.
- Read data is visible in the same cycle as `pready`. The master samples it at the negedge.
- Write data is visible in memory after the completion posedge, so it is readable at the following negedge.
- Back-to-back: the master's IDLE cycle between transfers is required. A setup seen in the cycle immediately after completion is also accepted, giving the same behaviour from IDLE.

## Structure

- Shared package `apb_pkg` holds:
  - FSM state encoding (IDLE/SETUP/ACCESS).
  - `APB_AW = 12`, `APB_DW = 32`.
  - Error-check helper constants.
- Sub-module: instantiate the existing `sp_sram` as `u_mem`, keeping the hierarchy path `u_mem.mem` so benches can backdoor-load and peek.
- Target size is about 150–250 lines of RTL excluding `sp_sram`.

## Test plan

- **Reset:** assert `rst` mid-stream. Outputs are 0 within the same cycle (async). After release, an idle bus leaves `pready = 0`.
- **Zero-wait write/read:** with `WAIT_CYC = 0`, write `0xDEADBEEF` to `0x3FC`. Then `mem[255] = 0xDEADBEEF`. Reading `0x3FC` returns `0xDEADBEEF` with `pready` in the first access cycle and `pslverr = 0`.
- **Wait states:** with `WAIT_CYC = 3`, read `0x000` after backdoor `mem[0] = 0x12345678`. `pready` is low for exactly 3 access cycles, then high for 1 with `prdata = 0x12345678`.
- **Error:** write `0xA5A5A5A5` to `0x002` (misaligned) expects `pslverr = 1` with `pready` and `mem[0]` unchanged. With `MEM_DEPTH = 512`, reading `0x800` gives `pslverr = 1` and `prdata = 0`.
- **Abort and reset mid-write:** drop `psel` during the wait states of a write to `0x010` (`WAIT_CYC = 3`). `mem[4]` is unchanged, FSM is in IDLE, and the next read to `0x010` succeeds. Repeat with `rst` pulsed mid-write, again with no write committed.
- **Regression:** run the master model's 1024 random `apb_write`/`apb_read` sequence against `WAIT_CYC` = 0, 1 and 5, with zero mismatches against `u_mem.mem`.
